inv_round_engine: RTL and testbench

INV_ROUND_ENGINE -- requirements
Module: inv_round_engine

---
 rtl/inv_round_engine.sv | 178 +++++++++++++++++
 tb/tb_inv_round_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_round_engine.sv
// inv_round_engine: iterative AES-128 inverse cipher, one round per clock.
// Optional per-round trace output is enabled by defining INV_ROUND_TRACE_EN.
module inv_round_engine #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         done,
    output logic [127:0] data_out,
    output logic [127:0] key_out
);

    if (ROUNDS != 10) begin : g_bad_rounds
        $error("inv_round_engine: ROUNDS must be 10 (AES-128)");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   cnt_q;
    logic [127:0] st_q, key_q;
    logic [127:0] st_d, key_d;
    logic [127:0] sb_st, ark, mix;
    logic [31:0]  kw0, kw1, kw2, kw3;
    logic [7:0]   rcon;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
        };
    endfunction

    // key_q holds k(cnt+1); Rcon index is therefore cnt+1.
    always_comb begin
        rcon = 8'h00;
        unique case (cnt_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        kw3 = key_q[31:0] ^ key_q[63:32];
        kw2 = key_q[63:32] ^ key_q[95:64];
        kw1 = key_q[95:64] ^ key_q[127:96];
        kw0 = key_q[127:96] ^ sub_word({kw3[23:0], kw3[31:24]}) ^ {rcon, 24'h0};
    end

    assign key_d = {kw0, kw1, kw2, kw3};

    // Byte (row r, col c) sits at index r+4c; row r rotates right by r.
    always_comb begin
        sb_st = '0;
        mix   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb_st[127-8*(r+4*c) -: 8] =
                    inv_sbox(st_q[127-8*(r+4*((c-r+4)%4)) -: 8]);
            end
        end
        ark = sb_st ^ key_d;
        for (int c = 0; c < 4; c++) begin
            mix[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
        end
        st_d = (cnt_q == 4'd0) ? ark : mix;
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    fsm_d = start ? RUN : IDLE;
            DONE:    fsm_d = start ? RUN : IDLE;
            RUN:     if (cnt_q == 4'd0) fsm_d = DONE;
            default: fsm_d = IDLE;
        endcase
    end

    assign ready = (fsm_q != RUN);
    assign done  = (fsm_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= IDLE;
            cnt_q    <= 4'd0;
            st_q     <= '0;
            key_q    <= '0;
            data_out <= '0;
            key_out  <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (ready && start) begin
                st_q  <= data_in ^ key_in;
                key_q <= key_in;
                cnt_q <= 4'(ROUNDS - 1);
            end else if (fsm_q == RUN) begin
                st_q  <= st_d;
                key_q <= key_d;
                if (cnt_q == 4'd0) begin
                    data_out <= st_d;
                    key_out  <= key_d;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

`ifdef INV_ROUND_TRACE_EN
    always @(posedge clk) begin
        if (!rst && fsm_q == RUN)
            $display("inv_round r=%0d key=%h state=%h", cnt_q, key_d, st_d);
        if (!rst && fsm_q == DONE)
            $display("inv_round done data_out=%h key_out=%h", data_out, key_out);
    end
`endif

endmodule

// File: tb/tb_inv_round_engine.sv
// tb_inv_round_engine: directed AES vectors plus random blocks checked
// against a forward AES-128 encryption model.
module tb_inv_round_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data_in, key_in;
    logic         ready, done;
    logic [127:0] data_out, key_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] R2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    inv_round_engine #(.ROUNDS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .key_in   (key_in),
        .ready    (ready),
        .done     (done),
        .data_out (data_out),
        .key_out  (key_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk GF(2^8)* with generator 3 and its inverse to fill the S-box.
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    task automatic aes_enc(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [31:0] tmp;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++)
            s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = sb[s[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    // Called just after a clock edge; the next edge is the accept edge.
    task automatic accept(input string tag, input logic [127:0] d,
                          input logic [127:0] k);
        chk({tag, "_ready"}, ready, 1);
        start   = 1'b1;
        data_in = d;
        key_in  = k;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = rnd128();
        key_in  = rnd128();
        chk({tag, "_busy"}, ready, 0);
    endtask

    task automatic await_done(input string tag, input bit poke,
                              input logic [127:0] prev);
        int lat;
        int leak;
        lat  = 0;
        leak = 0;
        while (lat < 20) begin
            start = poke && (lat == 3 || lat == 7);
            if (start) begin
                data_in = rnd128();
                key_in  = rnd128();
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (data_out !== prev) leak++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, lat, 10);
        chk({tag, "_hold"}, leak, 0);
    endtask

    task automatic check_result(input string tag, input logic [127:0] ed,
                                input logic [127:0] ek);
        chk({tag, "_dout"}, data_out, ed);
        chk({tag, "_kout"}, key_out, ek);
    endtask

    task automatic step_after_done(input string tag, input logic [127:0] ed);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_keep"}, data_out, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt, k, ct, k10;
        int ndone;
        build_sbox();
        rst = 1'b1;
        start = 1'b0;
        data_in = '0;
        key_in = '0;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_kout", key_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        accept("v1", C1, K1);
        await_done("v1", 1'b0, 128'h0);
        check_result("v1", P1, R1);
        step_after_done("v1", P1);

        accept("b2b_a", C1, K1);
        await_done("b2b_a", 1'b0, P1);
        check_result("b2b_a", P1, R1);
        accept("b2b_b", C2, K2);
        await_done("b2b_b", 1'b0, P1);
        check_result("b2b_b", P2, R2);
        step_after_done("b2b_b", P2);

        accept("poke", C1, K1);
        await_done("poke", 1'b1, P2);
        check_result("poke", P1, R1);
        step_after_done("poke", P1);

        accept("abort", C1, K1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_dout", data_out, 0);
        chk("abort_kout", key_out, 0);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        #2;
        rst = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        accept("rerun", C2, K2);
        await_done("rerun", 1'b0, 128'h0);
        check_result("rerun", P2, R2);
        step_after_done("rerun", P2);

        for (int i = 0; i < 8; i++) begin
            pt = rnd128();
            k  = rnd128();
            aes_enc(pt, k, ct, k10);
            accept("rand", ct, k10);
            await_done("rand", i[0], data_out);
            check_result("rand", pt, k);
            if (i % 3 == 2) step_after_done("rand", pt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
